// File: rtl/antfarm_pkg.sv
// rtl/antfarm_pkg.sv - shared ant-farm tile codes, default palette and overlay offsets
// Purpose: constants shared by the display path; default_color() gives the
// power-on palette entry for a register index.
// Ports: none (package).
package antfarm_pkg;

    localparam int COLOR_W = 9;

    localparam int TYPE_EMPTY  = 0;
    localparam int TYPE_AIR    = 1;
    localparam int TYPE_DIRT   = 2;
    localparam int TYPE_GROUND = 3;
    localparam int TYPE_QUEEN  = 4;
    localparam int TYPE_WALL   = 5;
    localparam int TYPE_ERROR  = 6;
    localparam int TYPE_TUNNEL = 7;

    localparam logic [COLOR_W-1:0] CLR_EMPTY  = 9'b000_000_000;
    localparam logic [COLOR_W-1:0] CLR_AIR    = 9'b011_010_000;
    localparam logic [COLOR_W-1:0] CLR_DIRT   = 9'b010_000_000;
    localparam logic [COLOR_W-1:0] CLR_GROUND = 9'b011_000_000;
    localparam logic [COLOR_W-1:0] CLR_QUEEN  = 9'b100_000_000;
    localparam logic [COLOR_W-1:0] CLR_WALL   = 9'b110_000_000;
    localparam logic [COLOR_W-1:0] CLR_ERROR  = 9'b111_111_111;
    localparam logic [COLOR_W-1:0] CLR_TUNNEL = 9'b111_000_000;
    localparam logic [COLOR_W-1:0] CLR_ANT    = 9'b111_100_000;
    localparam logic [COLOR_W-1:0] CLR_SUGAR  = 9'b111_010_000;

    // Overlay registers live directly above the type entries.
    localparam int ANT_OFS   = 0;
    localparam int SUGAR_OFS = 1;

    function automatic logic [COLOR_W-1:0] default_color(input int idx, input int num_types);
        logic [COLOR_W-1:0] c;
        c = '0;
        if (idx == num_types + ANT_OFS) begin
            c = CLR_ANT;
        end else if (idx == num_types + SUGAR_OFS) begin
            c = CLR_SUGAR;
        end else begin
            case (idx)
                TYPE_EMPTY:  c = CLR_EMPTY;
                TYPE_AIR:    c = CLR_AIR;
                TYPE_DIRT:   c = CLR_DIRT;
                TYPE_GROUND: c = CLR_GROUND;
                TYPE_QUEEN:  c = CLR_QUEEN;
                TYPE_WALL:   c = CLR_WALL;
                TYPE_ERROR:  c = CLR_ERROR;
                TYPE_TUNNEL: c = CLR_TUNNEL;
                default:     c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - frame counter and blink phase toggle for error tiles
// Purpose: counts frame_tick pulses 0..BLINK_FRAMES-1 and toggles blink_phase on wrap.
// Ports: clk, rst (async active-high), frame_tick, blink_en in; blink_phase out.
module blink_gen #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic blink_en,
    output logic blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_en) begin
            // Disabled: park in a known state so re-enabling starts a fresh half-period.
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (frame_tick) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/tile_palette.sv
// rtl/tile_palette.sv - programmable tile colour lookup with overlays and error blink
// Purpose: 2-stage pipeline turning tile type + ant/sugar flags into RGB333 via a
// writable palette register file.
// Ports: clk, rst (async active-high); frame_tick, blink_en (blink control);
// px_valid/px_type/px_ant/px_sugar (pixel request); wr_en/wr_addr/wr_data (palette
// write) with wr_err pulse; color_valid/color (resolved output).
module tile_palette
    import antfarm_pkg::*;
#(
    parameter int COLOR_W      = antfarm_pkg::COLOR_W,
    parameter int TYPE_W       = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int ERR_TYPE     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               blink_en,
    input  logic               px_valid,
    input  logic [TYPE_W-1:0]  px_type,
    input  logic               px_ant,
    input  logic               px_sugar,
    input  logic               wr_en,
    input  logic [TYPE_W:0]    wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_err,
    output logic               color_valid,
    output logic [COLOR_W-1:0] color
);

    localparam int NUM_TYPES   = 2 ** TYPE_W;
    localparam int NUM_ENTRIES = NUM_TYPES + 2;
    localparam int ANT_IDX     = NUM_TYPES + ANT_OFS;
    localparam int SUGAR_IDX   = NUM_TYPES + SUGAR_OFS;
    localparam logic [TYPE_W-1:0] ERR_CODE = TYPE_W'(ERR_TYPE);
    localparam logic [TYPE_W:0]   MAX_ADDR = (TYPE_W + 1)'(NUM_TYPES + 1);

    logic [COLOR_W-1:0] palette_q [NUM_ENTRIES];
    logic [COLOR_W-1:0] palette_d [NUM_ENTRIES];
    logic               wr_err_q, wr_err_d;

    logic               s1_valid_q, s1_valid_d;
    logic [TYPE_W-1:0]  s1_type_q, s1_type_d;
    logic               s1_ant_q, s1_ant_d;
    logic               s1_sugar_q, s1_sugar_d;

    logic               color_valid_q, color_valid_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [COLOR_W-1:0] resolved;
    logic               blink_phase;

    blink_gen #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_gen (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .blink_en   (blink_en),
        .blink_phase(blink_phase)
    );

    // Palette write port; stage 2 reads palette_q, so a same-cycle write to the
    // entry being looked up is seen only by later pixels.
    always_comb begin
        palette_d = palette_q;
        wr_err_d  = 1'b0;
        if (wr_en) begin
            if (wr_addr <= MAX_ADDR) begin
                palette_d[wr_addr] = wr_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        s1_valid_d = px_valid;
        s1_type_d  = px_type;
        s1_ant_d   = px_ant;
        s1_sugar_d = px_sugar;
    end

    // Error tiles win over overlays so a faulty cell stays visible under ants.
    always_comb begin
        if (s1_type_q == ERR_CODE) begin
            resolved = blink_phase ? '0 : palette_q[ERR_TYPE];
        end else if (s1_ant_q) begin
            resolved = palette_q[ANT_IDX];
        end else if (s1_sugar_q) begin
            resolved = palette_q[SUGAR_IDX];
        end else begin
            resolved = palette_q[{1'b0, s1_type_q}];
        end
        color_valid_d = s1_valid_q;
        color_d       = s1_valid_q ? resolved : color_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                palette_q[i] <= COLOR_W'(default_color(i, NUM_TYPES));
            end
            wr_err_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_type_q     <= '0;
            s1_ant_q      <= 1'b0;
            s1_sugar_q    <= 1'b0;
            color_valid_q <= 1'b0;
            color_q       <= '0;
        end else begin
            palette_q     <= palette_d;
            wr_err_q      <= wr_err_d;
            s1_valid_q    <= s1_valid_d;
            s1_type_q     <= s1_type_d;
            s1_ant_q      <= s1_ant_d;
            s1_sugar_q    <= s1_sugar_d;
            color_valid_q <= color_valid_d;
            color_q       <= color_d;
        end
    end

    assign wr_err      = wr_err_q;
    assign color_valid = color_valid_q;
    assign color       = color_q;

endmodule
